// File: rtl/title_screen_compositor_if.sv
// ============================================================================
// Module  : title_screen_compositor_if
// Purpose : Layer bus between the compositor and the external bitmap modules.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface title_screen_compositor_if #(
    parameter int N_LAYERS = 4
);
    logic [N_LAYERS*11-1:0] layerOffsetX;
    logic [N_LAYERS*11-1:0] layerOffsetY;
    logic [N_LAYERS-1:0]    layerInside;
    logic [N_LAYERS-1:0]    layerDR;
    logic [N_LAYERS*8-1:0]  layerRGB;

    modport master (
        output layerOffsetX,
        output layerOffsetY,
        output layerInside,
        input  layerDR,
        input  layerRGB
    );

    modport slave (
        input  layerOffsetX,
        input  layerOffsetY,
        input  layerInside,
        output layerDR,
        output layerRGB
    );
endinterface

`default_nettype wire

// File: rtl/title_screen_compositor.sv
// ============================================================================
// Module  : title_screen_compositor
// Purpose : Places, slides in, blinks and priority-muxes title-screen layers.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module title_screen_compositor #(
    parameter int                     N_LAYERS    = 4,
    parameter logic [N_LAYERS*11-1:0] LAYER_X     = {N_LAYERS{11'd0}},
    parameter logic [N_LAYERS*11-1:0] LAYER_Y     = {N_LAYERS{11'd0}},
    parameter logic [N_LAYERS*11-1:0] LAYER_W     = {N_LAYERS{11'd32}},
    parameter logic [N_LAYERS*11-1:0] LAYER_H     = {N_LAYERS{11'd32}},
    parameter logic [N_LAYERS-1:0]    SLIDE_MASK  = N_LAYERS'(1),
    parameter logic [N_LAYERS-1:0]    BLINK_MASK  = N_LAYERS'(2),
    parameter logic [10:0]            SLIDE_START = 11'd480,
    parameter logic [10:0]            SLIDE_STEP  = 11'd4,
    parameter int                     BLINK_HALF  = 30
) (
    input  wire                        clk,
    input  wire                        resetN,
    input  wire                        startOfFrame,
    input  wire                        standBy,
    input  wire [10:0]                 pixelX,
    input  wire [10:0]                 pixelY,
    title_screen_compositor_if.master  layer_bus,
    output logic                       startScreenDR,
    output logic [7:0]                 startScreenRGB,
    output logic                       introDone
);

    localparam int                 C_CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLIDE = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [10:0]          r_slide_off, w_slide_nxt;
    logic [C_CNT_W-1:0]   r_blink_cnt, w_blink_cnt_nxt;
    logic                 r_blink_on, w_blink_on_nxt;

    logic [N_LAYERS*11-1:0] w_off_x, w_off_y, r_off_x, r_off_y;
    logic [N_LAYERS-1:0]    w_inside, r_inside, w_en;
    logic [7:0]             w_rgb;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_slide_off <= SLIDE_START;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_slide_off <= w_slide_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_slide_nxt     = r_slide_off;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        // Leaving standBy always wins, so a frame pulse in the same cycle is ignored.
        if (!standBy) begin
            w_state_nxt     = S_IDLE;
            w_slide_nxt     = SLIDE_START;
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt     = S_SLIDE;
                    w_slide_nxt     = SLIDE_START;
                    w_blink_cnt_nxt = '0;
                    w_blink_on_nxt  = 1'b1;
                end
                S_SLIDE: begin
                    if (r_slide_off == 11'd0) begin
                        w_state_nxt = S_SHOW;
                    end else if (startOfFrame) begin
                        w_slide_nxt = r_slide_off -
                            ((r_slide_off < SLIDE_STEP) ? r_slide_off : SLIDE_STEP);
                    end
                end
                S_SHOW: begin
                    if (startOfFrame) begin
                        if (r_blink_cnt == C_LAST) begin
                            w_blink_cnt_nxt = '0;
                            w_blink_on_nxt  = ~r_blink_on;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign introDone = (r_state == S_SHOW);

    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
        logic signed [11:0] w_eff_y, w_eff_y_end, w_py, w_dy;
        logic        [11:0] w_x_end;
        logic               w_in;

        // Vertical placement is signed so a layer parked above the screen stays outside.
        assign w_eff_y     = $signed({1'b0, LAYER_Y[gi*11 +: 11]}) -
                             (SLIDE_MASK[gi] ? $signed({1'b0, r_slide_off}) : 12'sd0);
        assign w_eff_y_end = w_eff_y + $signed({1'b0, LAYER_H[gi*11 +: 11]});
        assign w_py        = $signed({1'b0, pixelY});
        assign w_dy        = w_py - w_eff_y;
        assign w_x_end     = {1'b0, LAYER_X[gi*11 +: 11]} + {1'b0, LAYER_W[gi*11 +: 11]};
        assign w_in        = ({1'b0, pixelX} >= {1'b0, LAYER_X[gi*11 +: 11]}) &&
                             ({1'b0, pixelX} < w_x_end) &&
                             (w_py >= w_eff_y) && (w_py < w_eff_y_end);

        assign w_inside[gi]        = w_in;
        assign w_off_x[gi*11 +: 11] = w_in ? (pixelX - LAYER_X[gi*11 +: 11]) : 11'd0;
        assign w_off_y[gi*11 +: 11] = w_in ? w_dy[10:0] : 11'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_off_x  <= '0;
            r_off_y  <= '0;
            r_inside <= '0;
        end else begin
            r_off_x  <= w_off_x;
            r_off_y  <= w_off_y;
            r_inside <= w_inside;
        end
    end

    assign layer_bus.layerOffsetX = r_off_x;
    assign layer_bus.layerOffsetY = r_off_y;
    assign layer_bus.layerInside  = r_inside;

    assign w_en = layer_bus.layerDR & {N_LAYERS{standBy}} &
                  ~(BLINK_MASK & {N_LAYERS{~r_blink_on}});

    always_comb begin
        w_rgb = 8'h00;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (w_en[i]) w_rgb = layer_bus.layerRGB[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            startScreenDR  <= 1'b0;
            startScreenRGB <= 8'h00;
        end else begin
            startScreenDR  <= |w_en;
            startScreenRGB <= w_rgb;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_title_screen_compositor.sv
// ============================================================================
// Module  : tb_title_screen_compositor
// Purpose : Self-checking bench for two differently configured compositors.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_title_screen_compositor;

    localparam logic [43:0] A_X = {11'd500, 11'd100, 11'd70,  11'd100};
    localparam logic [43:0] A_Y = {11'd400, 11'd240, 11'd230, 11'd300};
    localparam logic [43:0] A_W = {11'd50,  11'd200, 11'd128, 11'd32};
    localparam logic [43:0] A_H = {11'd50,  11'd100, 11'd77,  11'd32};
    localparam logic [43:0] B_X = {11'd500, 11'd100, 11'd70,  11'd0};
    localparam logic [43:0] B_Y = {11'd400, 11'd240, 11'd230, 11'd20};

    logic        clk = 1'b0;
    logic        resetN, standBy, startOfFrame;
    logic [10:0] pixelX, pixelY;
    logic [3:0]  tb_dr, cap_inside;
    logic [31:0] tb_rgb;
    logic        bitmap_mode, rand_sb;
    logic        drA, drB, doneA, doneB;
    logic [7:0]  rgbA, rgbB;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    title_screen_compositor_if #(.N_LAYERS(4)) busA ();
    title_screen_compositor_if #(.N_LAYERS(4)) busB ();
    assign busA.layerDR  = tb_dr;
    assign busA.layerRGB = tb_rgb;
    assign busB.layerDR  = tb_dr;
    assign busB.layerRGB = tb_rgb;

    title_screen_compositor #(
        .N_LAYERS(4), .LAYER_X(A_X), .LAYER_Y(A_Y), .LAYER_W(A_W), .LAYER_H(A_H),
        .SLIDE_MASK(4'b0001), .BLINK_MASK(4'b0010),
        .SLIDE_START(11'd480), .SLIDE_STEP(11'd4), .BLINK_HALF(2)
    ) dutA (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .standBy(standBy),
        .pixelX(pixelX), .pixelY(pixelY), .layer_bus(busA),
        .startScreenDR(drA), .startScreenRGB(rgbA), .introDone(doneA)
    );

    title_screen_compositor #(
        .N_LAYERS(4), .LAYER_X(B_X), .LAYER_Y(B_Y), .LAYER_W(A_W), .LAYER_H(A_H),
        .SLIDE_MASK(4'b0011), .BLINK_MASK(4'b0100),
        .SLIDE_START(11'd10), .SLIDE_STEP(11'd4), .BLINK_HALF(3)
    ) dutB (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .standBy(standBy),
        .pixelX(pixelX), .pixelY(pixelY), .layer_bus(busB),
        .startScreenDR(drB), .startScreenRGB(rgbB), .introDone(doneB)
    );

    // Reference model: configuration, frame counters and expected outputs per DUT.
    int         c_x[2][4], c_y[2][4], c_w[2][4], c_h[2][4];
    int         c_start[2], c_step[2], c_half[2];
    logic [3:0] c_smask[2], c_bmask[2];
    bit         m_active[2], m_show[2];
    int         m_sofs[2], m_show_sofs[2];
    logic [43:0] e_offx[2], e_offy[2];
    logic [3:0]  e_in[2];
    logic        e_dr[2], e_done[2];
    logic [7:0]  e_rgb[2];

    function automatic int slide_of(input int d);
        int v;
        v = c_start[d] - c_step[d] * m_sofs[d];
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit blink_on(input int d);
        return ((m_show_sofs[d] / c_half[d]) % 2) == 0;
    endfunction

    task automatic model_edge(input int d);
        int sl, effy, px, py;
        bit on, dr;
        logic [7:0] rgb;
        if (!resetN) begin
            m_active[d] = 0; m_show[d] = 0; m_sofs[d] = 0; m_show_sofs[d] = 0;
            e_offx[d] = '0; e_offy[d] = '0; e_in[d] = '0;
            e_dr[d] = 1'b0; e_rgb[d] = 8'h00; e_done[d] = 1'b0;
            return;
        end
        px = int'(pixelX); py = int'(pixelY);
        sl = slide_of(d); on = blink_on(d);
        for (int l = 0; l < 4; l++) begin
            effy = c_y[d][l] - (c_smask[d][l] ? sl : 0);
            if (px >= c_x[d][l] && px < c_x[d][l] + c_w[d][l] &&
                py >= effy && py < effy + c_h[d][l]) begin
                e_in[d][l] = 1'b1;
                e_offx[d][l*11 +: 11] = 11'(px - c_x[d][l]);
                e_offy[d][l*11 +: 11] = 11'(py - effy);
            end else begin
                e_in[d][l] = 1'b0;
                e_offx[d][l*11 +: 11] = 11'd0;
                e_offy[d][l*11 +: 11] = 11'd0;
            end
        end
        dr = 0; rgb = 8'h00;
        for (int l = 0; l < 4; l++) begin
            if (!dr && tb_dr[l] && standBy && !(c_bmask[d][l] && !on)) begin
                dr = 1; rgb = tb_rgb[l*8 +: 8];
            end
        end
        e_dr[d] = dr; e_rgb[d] = rgb;
        if (!standBy) begin
            m_active[d] = 0; m_show[d] = 0; m_sofs[d] = 0; m_show_sofs[d] = 0;
        end else if (!m_active[d]) begin
            m_active[d] = 1;
        end else if (!m_show[d]) begin
            if (sl == 0) m_show[d] = 1;
            else if (startOfFrame) m_sofs[d]++;
        end else if (startOfFrame) begin
            m_show_sofs[d]++;
        end
        e_done[d] = m_show[d];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("A.offX", 64'(busA.layerOffsetX), 64'(e_offx[0]));
        chk("A.offY", 64'(busA.layerOffsetY), 64'(e_offy[0]));
        chk("A.inside", 64'(busA.layerInside), 64'(e_in[0]));
        chk("A.DR", 64'(drA), 64'(e_dr[0]));
        chk("A.RGB", 64'(rgbA), 64'(e_rgb[0]));
        chk("A.introDone", 64'(doneA), 64'(e_done[0]));
        chk("B.offX", 64'(busB.layerOffsetX), 64'(e_offx[1]));
        chk("B.offY", 64'(busB.layerOffsetY), 64'(e_offy[1]));
        chk("B.inside", 64'(busB.layerInside), 64'(e_in[1]));
        chk("B.DR", 64'(drB), 64'(e_dr[1]));
        chk("B.RGB", 64'(rgbB), 64'(e_rgb[1]));
        chk("B.introDone", 64'(doneB), 64'(e_done[1]));
        // Opaque bitmaps: drawing request is layerInside delayed by one register.
        if (bitmap_mode) tb_dr = cap_inside;
        cap_inside = busA.layerInside;
    endtask

    task automatic rand_inputs();
        pixelX = 11'($urandom_range(0, 700));
        pixelY = 11'($urandom_range(0, 520));
        if (rand_sb) standBy = ($urandom_range(0, 59) != 0);
        if (!bitmap_mode) begin
            tb_dr  = 4'($urandom);
            tb_rgb = $urandom;
        end
    endtask

    task automatic run_frame(input int len);
        startOfFrame = 1'b1;
        rand_inputs();
        tick();
        startOfFrame = 1'b0;
        for (int i = 1; i < len; i++) begin
            rand_inputs();
            tick();
        end
    endtask

    task automatic set_px(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] sat_seq [5];
        logic [5:0]  blink_exp;
        sat_seq   = '{11'd10, 11'd6, 11'd2, 11'd0, 11'd0};
        blink_exp = 6'b110011;

        for (int l = 0; l < 4; l++) begin
            c_x[0][l] = int'(A_X[l*11 +: 11]); c_y[0][l] = int'(A_Y[l*11 +: 11]);
            c_x[1][l] = int'(B_X[l*11 +: 11]); c_y[1][l] = int'(B_Y[l*11 +: 11]);
            c_w[0][l] = int'(A_W[l*11 +: 11]); c_h[0][l] = int'(A_H[l*11 +: 11]);
            c_w[1][l] = c_w[0][l];             c_h[1][l] = c_h[0][l];
        end
        c_start = '{480, 10}; c_step = '{4, 4}; c_half = '{2, 3};
        c_smask = '{4'b0001, 4'b0011}; c_bmask = '{4'b0010, 4'b0100};

        resetN = 1'b0; standBy = 1'b1; startOfFrame = 1'b0;
        bitmap_mode = 1'b0; rand_sb = 1'b0; cap_inside = '0;
        rand_inputs();
        #3;
        tick(); rand_inputs(); startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("reset.A.inside", 64'(busA.layerInside), 64'd0);
        chk("reset.A.DR", 64'(drA), 64'd0);
        chk("reset.A.introDone", 64'(doneA), 64'd0);

        // Release with standBy high; B's slide of 10 by 4 must saturate at 0.
        resetN = 1'b1;
        set_px(0, 20);
        tick();
        chk("sat.B.slide0", 64'(busB.layerOffsetY[10:0]), 64'(sat_seq[0]));
        for (int k = 1; k < 5; k++) begin
            startOfFrame = 1'b1; rand_inputs(); tick(); startOfFrame = 1'b0;
            set_px(0, 20); tick();
            chk($sformatf("sat.B.slide%0d", k), 64'(busB.layerOffsetY[10:0]), 64'(sat_seq[k]));
        end

        for (int f = 4; f < 60; f++) run_frame($urandom_range(3, 6));
        set_px(100, 60); tick();
        chk("slide60.A.inside0", 64'(busA.layerInside[0]), 64'd1);
        chk("slide60.A.offY0", 64'(busA.layerOffsetY[10:0]), 64'd0);
        set_px(100, 59); tick();
        chk("slide60.A.above", 64'(busA.layerInside[0]), 64'd0);

        for (int f = 60; f < 119; f++) run_frame($urandom_range(3, 6));
        chk("intro.A.pending", 64'(doneA), 64'd0);
        startOfFrame = 1'b1; rand_inputs(); tick(); startOfFrame = 1'b0;
        chk("intro.A.sof120", 64'(doneA), 64'd0);
        rand_inputs(); tick();
        chk("intro.A.plus1", 64'(doneA), 64'd1);

        set_px(70, 230); tick();
        chk("geom.in", 64'(busA.layerInside[1]), 64'd1);
        chk("geom.offX", 64'(busA.layerOffsetX[21:11]), 64'd0);
        chk("geom.offY", 64'(busA.layerOffsetY[21:11]), 64'd0);
        set_px(197, 306); tick();
        chk("geom.corner.offX", 64'(busA.layerOffsetX[21:11]), 64'd127);
        chk("geom.corner.offY", 64'(busA.layerOffsetY[21:11]), 64'd76);
        set_px(198, 230); tick();
        chk("geom.right", 64'(busA.layerInside[1]), 64'd0);
        chk("geom.right.offX", 64'(busA.layerOffsetX[21:11]), 64'd0);

        bitmap_mode = 1'b1;
        tb_rgb = {8'h03, 8'hE0, 8'h55, 8'h1C};
        set_px(1000, 1000);
        for (int i = 0; i < 3; i++) tick();
        for (int f = 0; f < 6; f++) begin
            if (f > 0) begin
                startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
            end
            set_px(75, 235); tick();
            set_px(1000, 1000); tick(); tick();
            chk($sformatf("blink.f%0d.DR", f), 64'(drA), 64'(blink_exp[f]));
            chk($sformatf("blink.f%0d.RGB", f), 64'(rgbA), blink_exp[f] ? 64'h55 : 64'h00);
        end

        tick();
        set_px(110, 310); tick();
        set_px(1000, 1000); tick();
        chk("prio.early", 64'(drA), 64'd0);
        tick();
        chk("prio.DR", 64'(drA), 64'd1);
        chk("prio.RGB", 64'(rgbA), 64'h1C);
        tick();
        chk("prio.after", 64'(drA), 64'd0);

        set_px(110, 310);
        for (int i = 0; i < 4; i++) tick();
        chk("drop.before", 64'(drA), 64'd1);
        standBy = 1'b0; startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("drop.DR", 64'(drA), 64'd0);
        chk("drop.introDone", 64'(doneA), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        standBy = 1'b1; set_px(0, 20); tick();
        chk("replay.B.slide", 64'(busB.layerOffsetY[10:0]), 64'd10);

        bitmap_mode = 1'b0; rand_sb = 1'b1;
        for (int f = 0; f < 150; f++) run_frame($urandom_range(3, 6));
        rand_sb = 1'b0; standBy = 1'b1;
        for (int f = 0; f < 8; f++) run_frame(4);

        #3 resetN = 1'b0;
        #1;
        chk("areset.A.offX", 64'(busA.layerOffsetX), 64'd0);
        chk("areset.A.offY", 64'(busA.layerOffsetY), 64'd0);
        chk("areset.A.inside", 64'(busA.layerInside), 64'd0);
        chk("areset.A.DR", 64'(drA), 64'd0);
        chk("areset.A.RGB", 64'(rgbA), 64'd0);
        chk("areset.B.introDone", 64'(doneB), 64'd0);
        tick(); tick();
        resetN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_inputs(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
